// File: rtl/alu_seq.sv
// alu_seq: multi-cycle integer ALU for RV32I OP/OP-IMM arithmetic.
// start/busy/done handshake, iterative shifter (SHIFT_STEP bits per cycle),
// carry/overflow flags and a kill input that drops the in-flight operation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold the last completed result
// S_EXEC  | single-edge evaluation of add/sub/logic/compare ops
// S_SHIFT | shifting the working register until remaining reaches 0
module alu_seq #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [6:0]      fun7,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] res,
  output logic            zero,
  output logic            neg,
  output logic            carry,
  output logic            ovf,
  output logic            busy,
  output logic            done
);

  localparam int SHW = $clog2(XLEN);
  // One extra bit so SHIFT_STEP == XLEN is representable.
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  localparam logic [2:0] F_ADD  = 3'b000;
  localparam logic [2:0] F_SLL  = 3'b001;
  localparam logic [2:0] F_SLT  = 3'b010;
  localparam logic [2:0] F_SLTU = 3'b011;
  localparam logic [2:0] F_XOR  = 3'b100;
  localparam logic [2:0] F_SR   = 3'b101;
  localparam logic [2:0] F_OR   = 3'b110;
  localparam logic [2:0] F_AND  = 3'b111;

  logic [1:0]      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            alt_q, alt_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] exec_res;
  logic            exec_ovf;
  logic            lt_s, lt_u;
  logic [SHW:0]    step;
  logic            last_step;
  logic [XLEN-1:0] shifted;

  // Only fun7[5] carries meaning for this op subset.
  logic unused_fun7;
  assign unused_fun7 = ^{fun7[6], fun7[4:0]};

  // Single-edge datapath: SUB is a + ~b + 1, so carry-out doubles as no-borrow.
  always_comb begin
    b_eff    = alt_q ? ~b_q : b_q;
    sum      = {1'b0, a_q} + {1'b0, b_eff} + {{XLEN{1'b0}}, alt_q};
    exec_ovf = (a_q[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a_q[XLEN-1]);
    lt_s     = $signed(a_q) < $signed(b_q);
    lt_u     = a_q < b_q;
    case (op_q)
      F_AND:   exec_res = a_q & b_q;
      F_OR:    exec_res = a_q | b_q;
      F_XOR:   exec_res = a_q ^ b_q;
      F_SLT:   exec_res = {{(XLEN-1){1'b0}}, lt_s};
      F_SLTU:  exec_res = {{(XLEN-1){1'b0}}, lt_u};
      default: exec_res = sum[XLEN-1:0];
    endcase
  end

  // Shifter step: move by min(SHIFT_STEP, remaining); arithmetic shift keeps the rs1 sign.
  always_comb begin
    step      = ({1'b0, rem_q} < STEP) ? {1'b0, rem_q} : STEP;
    last_step = ({1'b0, rem_q} <= STEP);
    if (op_q == F_SLL) begin
      shifted = a_q << step;
    end else if (alt_q) begin
      shifted = $signed(a_q) >>> step;
    end else begin
      shifted = a_q >> step;
    end
  end

  // Sequencer next-state: kill beats both start and completion.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    alt_d   = alt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d    = fun3;
          alt_d   = fun7[5];
          a_d     = rs1;
          b_d     = rs2;
          rem_d   = rs2[SHW-1:0];
          busy_d  = 1'b1;
          state_d = (fun3 == F_SLL || fun3 == F_SR) ? S_SHIFT : S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!kill) begin
          res_d   = exec_res;
          carry_d = (op_q == F_ADD) ? sum[XLEN] : 1'b0;
          ovf_d   = (op_q == F_ADD) ? exec_ovf : 1'b0;
          done_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (kill) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          a_d   = shifted;
          rem_d = rem_q - step[SHW-1:0];
          if (last_step) begin
            res_d   = shifted;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      alt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      alt_q   <= alt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign res   = res_q;
  assign zero  = (res_q == '0);
  assign neg   = res_q[XLEN-1];
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases followed by random ops
// compared against an arithmetic reference model.
module tb_alu_seq;
  localparam int XLEN = 32;
  localparam int STEP = 1;
  localparam longint SMAX = (longint'(1) << (XLEN-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (XLEN-1));

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            kill = 1'b0;
  logic [6:0]      fun7 = '0;
  logic [2:0]      fun3 = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic [XLEN-1:0] res;
  logic            zero, neg, carry, ovf, busy, done;

  int checks = 0;
  int failures = 0;

  alu_seq #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .kill(kill),
    .fun7(fun7), .fun3(fun3), .rs1(rs1), .rs2(rs2),
    .res(res), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] r;
    logic            c;
    logic            v;
    int              lat;
  } exp_t;

  function automatic exp_t model(input logic [2:0] f3, input logic alt,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    longint sa, sb, ss;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % XLEN);
    e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.r = '0;
    case (f3)
      3'b000: begin
        if (alt) begin
          e.r = a - b; e.c = (a >= b); ss = sa - sb;
        end else begin
          e.r = a + b; e.c = ((longint'(a) + longint'(b)) >> XLEN) != 0; ss = sa + sb;
        end
        e.v = (ss > SMAX) || (ss < SMIN);
      end
      3'b111: e.r = a & b;
      3'b110: e.r = a | b;
      3'b100: e.r = a ^ b;
      3'b010: e.r = (sa < sb) ? 1 : 0;
      3'b011: e.r = (a < b) ? 1 : 0;
      3'b001: e.r = a << sh;
      default: e.r = alt ? XLEN'($signed(a) >>> sh) : (a >> sh);
    endcase
    if (f3 == 3'b001 || f3 == 3'b101) e.lat = (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
    return e;
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [2:0] f3, input logic [6:0] f7,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    start = 1'b1; kill = 1'b0; fun3 = f3; fun7 = f7; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; fun3 = 3'($urandom); fun7 = 7'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    int n;
    e = model(f3, f7[5], a, b);
    accept(f3, f7, a, b);
    check({tag, ".busy"}, XLEN'(busy), 1);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ".lat"}, XLEN'(n), XLEN'(e.lat));
    check({tag, ".res"}, res, e.r);
    check({tag, ".zero"}, XLEN'(zero), XLEN'(e.r == '0));
    check({tag, ".neg"}, XLEN'(neg), XLEN'(e.r[XLEN-1]));
    check({tag, ".carry"}, XLEN'(carry), XLEN'(e.c));
    check({tag, ".ovf"}, XLEN'(ovf), XLEN'(e.v));
    check({tag, ".busy_end"}, XLEN'(busy), 0);
    @(posedge clk); #1;
    check({tag, ".done_fall"}, XLEN'(done), 0);
  endtask

  initial begin
    exp_t e1, e2;
    int ndone, first;
    logic [XLEN-1:0] prior;

    #2;
    check("rst.res", res, 0);
    check("rst.flags", XLEN'({zero, neg, carry, ovf, busy, done}), 32'b100000);
    @(negedge clk); reset_n = 1'b1;

    run_op("add_ovf", 3'b000, 7'h00, 32'h7FFFFFFF, 32'h00000001);
    run_op("sub_eq", 3'b000, 7'h20, 32'h5, 32'h5);
    run_op("sub_neg", 3'b000, 7'h20, 32'h0, 32'h1);
    run_op("sra4", 3'b101, 7'h20, 32'h80000000, 32'h4);
    run_op("srl4", 3'b101, 7'h00, 32'h80000000, 32'h4);
    run_op("slt", 3'b010, 7'h00, 32'hFFFFFFFF, 32'h1);
    run_op("sltu", 3'b011, 7'h00, 32'hFFFFFFFF, 32'h1);
    run_op("sll_21", 3'b001, 7'h00, 32'h1, 32'h21);
    run_op("sll_0", 3'b001, 7'h00, 32'hCAFE0001, 32'h40);
    run_op("add_carry", 3'b000, 7'h00, 32'hFFFFFFFF, 32'h2);

    // second start during a 31-bit SRL is dropped
    e1 = model(3'b101, 1'b0, 32'hF0000000, 32'd31);
    accept(3'b101, 7'h00, 32'hF0000000, 32'd31);
    ndone = 0; first = 0;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 2);
      fun3 = 3'b000; rs1 = 32'h11; rs2 = 32'h22;
      @(posedge clk); #1;
      if (done === 1'b1) begin ndone++; if (first == 0) first = k; end
    end
    start = 1'b0;
    check("ign.ndone", XLEN'(ndone), 1);
    check("ign.lat", XLEN'(first), XLEN'(e1.lat));
    check("ign.res", res, e1.r);

    // start held high through done: next op issues on the done cycle
    e1 = model(3'b000, 1'b0, 32'h100, 32'h23);
    e2 = model(3'b100, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F);
    @(negedge clk);
    start = 1'b1; fun3 = 3'b000; fun7 = 7'h00; rs1 = 32'h100; rs2 = 32'h23;
    @(posedge clk); #1;
    check("b2b.busy1", XLEN'(busy), 1);
    fun3 = 3'b100; rs1 = 32'hA5A5A5A5; rs2 = 32'h0F0F0F0F;
    @(posedge clk); #1;
    check("b2b.done1", XLEN'({done, busy}), 32'b10);
    check("b2b.res1", res, e1.r);
    @(posedge clk); #1;
    check("b2b.accept2", XLEN'({done, busy}), 32'b01);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b.done2", XLEN'({done, busy}), 32'b10);
    check("b2b.res2", res, e2.r);
    @(posedge clk); #1;
    check("b2b.done2_fall", XLEN'(done), 0);

    // kill three edges into a 20-bit shift
    run_op("pre_kill", 3'b000, 7'h00, 32'h1234, 32'h1);
    prior = res;
    accept(3'b001, 7'h00, 32'h1, 32'd20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill.busy_done", XLEN'({busy, done}), 0);
    check("kill.res", res, prior);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    check("kill.no_done", XLEN'(ndone), 0);
    check("kill.res_hold", res, prior);

    // kill in IDLE blocks start
    @(negedge clk); start = 1'b1; kill = 1'b1; fun3 = 3'b000; rs1 = 32'h9; rs2 = 32'h9;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("idle_kill.busy", XLEN'(busy), 0);
    @(posedge clk); #1;
    check("idle_kill.done", XLEN'(done), 0);
    check("idle_kill.res", res, prior);

    // asynchronous reset mid-shift
    accept(3'b101, 7'h00, 32'hFFFF0000, 32'd20);
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst.res", res, 0);
    check("arst.flags", XLEN'({zero, neg, carry, ovf, busy, done}), 32'b100000);
    @(negedge clk); reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    check("arst.quiet", XLEN'(ndone), 0);

    // random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic [6:0] f7;
      logic [XLEN-1:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom);
      run_op("rand", f3, f7, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Clocked, multi-cycle successor to the combinational integer ALU.
- Parametrised datapath width. Registered start/busy/done handshake. Iterative shifter processes SHIFT_STEP bits per cycle. Adds carry/overflow flags and a kill input.
- Sits between decode/issue and writeback in the CPU core and executes RV32I OP/OP-IMM arithmetic.

Parameters:
- XLEN, 32, datapath width in bits; power of two, >= 8.
- SHIFT_STEP, 1, shift distance applied per SHIFT cycle; power of two, 1..XLEN.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- kill  in  1  abort the in-flight operation.
- fun7  in  7  RISC-V funct7; bit 5 selects SUB/SRA.
- fun3  in  3  RISC-V funct3 operation select.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  operand B; low log2(XLEN) bits form the shift amount.
- res  out  XLEN  result; held until the next completion.
- zero  out  1  res == 0.
- neg  out  1  res[XLEN-1].
- carry  out  1  ADD: carry-out. SUB: no-borrow (rs1 >= rs2 unsigned). Otherwise 0.
- ovf  out  1  signed overflow of ADD/SUB; otherwise 0.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; res=0; zero=1; neg=0; carry=0; ovf=0; busy=0; done=0; internal counters cleared. Reset asserted mid-operation discards the operation with no done pulse.
- States:
  - IDLE: start=1 at an edge latches fun3, fun7[5], rs1, rs2 and shamt=rs2[log2(XLEN)-1:0], then sets busy=1. Shift ops (SLL=001, SRL/SRA=101) go to SHIFT; all others go to EXEC. start=0 holds in IDLE.
  - EXEC: one edge. Computes the result and flags, registers them, sets done=1 and busy=0, returns to IDLE.
  - SHIFT: each edge shifts the working register by min(SHIFT_STEP, remaining) and decrements remaining by the same amount. SRA fills with the latched rs1 sign bit; SLL/SRL fill with 0. On the edge where remaining reaches 0, registers res and flags, sets done=1 and busy=0, returns to IDLE. shamt=0 still spends exactly one SHIFT edge.
- Latency, measured in edges from the accepting edge to done high:
  - Non-shift ops: 1.
  - Shift ops: max(1, ceil(shamt/SHIFT_STEP)).
- Operations:
  - 000: ADD, or SUB when fun7[5]=1.
  - 111: AND. 110: OR. 100: XOR.
  - 001: SLL.
  - 101: SRL, or SRA when fun7[5]=1.
  - 010: SLT, signed compare, result 1 or 0.
  - 011: SLTU, unsigned compare, result 1 or 0.
- Widths and flags: all arithmetic is modulo 2^XLEN. zero and neg are derived from the registered res. carry and ovf are meaningful only for fun3=000.
- done handshake: high for exactly one cycle after completion and deasserts at the next edge. res and flags remain stable until the next completion or reset.
- Back-to-back issue: start high in the cycle done is high (state is IDLE) is accepted; busy rises at that edge.
- start while busy=1: ignored, not queued; the operation in flight is unaffected.
- kill=1 at an edge while busy: returns to IDLE with busy=0, no done, res and flags unchanged. kill has priority over a completion on the same edge.
- kill in IDLE has priority over start: the request is not accepted.
- Operand inputs may change freely after the accepting edge.

Test Plan:
- ADD: rs1=0x7FFFFFFF, rs2=0x00000001, fun3=000, fun7=0 -> done 1 edge after accept; res=0x80000000, neg=1, ovf=1, carry=0, zero=0.
- SUB: rs1=rs2=0x00000005, fun7=0x20 -> res=0, zero=1, carry=1, ovf=0. Then rs1=0, rs2=1 -> res=0xFFFFFFFF, carry=0, neg=1.
- SRA, SHIFT_STEP=1: rs1=0x80000000, rs2=4, fun3=101, fun7=0x20 -> busy for 4 SHIFT edges, res=0xF8000000. Repeat with SRL -> res=0x08000000. Repeat with SHIFT_STEP=4 -> done after 1 edge.
- SLT/SLTU: rs1=0xFFFFFFFF, rs2=1 -> SLT res=1; SLTU res=0. SLL with rs2=0x00000021 (shamt=1) on rs1=1 -> res=2. SLL with shamt=0 -> done after 1 SHIFT edge, res=rs1.
- Handshake: second start pulsed 2 cycles into a 31-bit SRL -> ignored, single done. start held high through done -> next op accepted on the done cycle, done pulses exactly once per op.
- Abort: kill 3 edges into a 20-bit shift -> busy=0, no done, res holds the prior value. reset_n low mid-shift -> all outputs at reset values immediately, without waiting for a clock edge.
